// File: rtl/bram_stream_reader.sv
`timescale 1ns/1ps
// Read-side BRAM master: turns an (address, length) command into back-to-back
// 1-cycle-latency BRAM reads and streams the words out over AXI-Stream.
module bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  bram_rden,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    rden_q, rden_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
    logic [LEN_WIDTH-1:0]    remain_q, remain_d;
    logic [LEN_WIDTH-1:0]    last_idx_q, last_idx_d;
    logic [LEN_WIDTH-1:0]    beat_q, beat_d;
    logic                    pend_q;
    logic                    done_q, done_d;

    logic [DATA_WIDTH-1:0]   fifo_q [4];
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [2:0]              count_q, count_d;

    logic                    push;
    logic                    pop;
    logic                    is_last;
    logic [3:0]              occ;
    logic                    credit_ok;

    // pend_q marks the cycle in which bram_dout carries a word we asked for
    assign push          = pend_q;
    assign m_axis_tvalid = (count_q != 3'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign is_last       = (beat_q == last_idx_q);
    assign m_axis_tlast  = m_axis_tvalid & is_last;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_q[rd_ptr_q] : '0;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign bram_rden = rden_q;
    assign bram_addr = addr_q;
    assign done      = done_q;

    // Slots committed after this edge: stored words, both in-flight reads, minus a pop.
    assign occ       = {1'b0, count_q} + {3'b000, rden_q} + {3'b000, pend_q} - {3'b000, pop};
    assign credit_ok = (occ < 4'd4);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rden_d      = 1'b0;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        remain_d    = remain_q;
        last_idx_d  = last_idx_q;
        beat_d      = beat_q;
        done_d      = 1'b0;

        if (pop) begin
            beat_d = beat_q + LEN_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    last_idx_d = cmd_len - LEN_WIDTH'(1);
                    beat_d     = '0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // first read goes out straight from the accept edge
                        rden_d      = 1'b1;
                        addr_d      = cmd_addr;
                        next_addr_d = cmd_addr + ADDR_WIDTH'(1);
                        remain_d    = cmd_len - LEN_WIDTH'(1);
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (remain_q == '0) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    rden_d      = 1'b1;
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    remain_d    = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && is_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rden_q      <= 1'b0;
            addr_q      <= '0;
            next_addr_q <= '0;
            remain_q    <= '0;
            last_idx_q  <= '0;
            beat_q      <= '0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            rden_q      <= rden_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            remain_q    <= remain_d;
            last_idx_q  <= last_idx_d;
            beat_q      <= beat_d;
            pend_q      <= rden_q;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset; pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bram_dout;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
`timescale 1ns/1ps
// Directed bench for bram_stream_reader: command table plus hand sequences for
// reset, zero length, mid-command reset and address wrap on a 4-bit instance.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;

    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic        bram_rden;
    logic [7:0]  bram_addr;
    logic [31:0] bram_dout;
    logic [31:0] tdata;
    logic        tvalid, tready, tlast, busy, done;

    logic        s_cmd_valid, s_cmd_ready;
    logic [3:0]  s_cmd_addr;
    logic [4:0]  s_cmd_len;
    logic        s_bram_rden;
    logic [3:0]  s_bram_addr;
    logic [31:0] s_bram_dout;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast, s_busy, s_done;

    logic [31:0] mem  [256];
    logic [31:0] smem [16];

    bram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LEN_WIDTH(9)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .bram_rden(bram_rden), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .busy(busy), .done(done)
    );

    bram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .LEN_WIDTH(5)) dut_small (
        .clk(clk), .rstn(rstn),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_addr(s_cmd_addr), .cmd_len(s_cmd_len),
        .bram_rden(s_bram_rden), .bram_addr(s_bram_addr), .bram_dout(s_bram_dout),
        .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready),
        .m_axis_tlast(s_tlast), .busy(s_busy), .done(s_done)
    );

    always @(posedge clk) begin
        if (bram_rden) bram_dout <= mem[bram_addr];
        if (s_bram_rden) s_bram_dout <= smem[s_bram_addr];
    end

    int    n_vec = 0;
    int    n_err = 0;
    string phase = "init";

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", phase, nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs();
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        chk("bram_rden", 32'(bram_rden), 32'd0);
        chk("bram_addr", 32'(bram_addr), 32'd0);
        chk("tvalid",    32'(tvalid),    32'd0);
        chk("tlast",     32'(tlast),     32'd0);
        chk("tdata",     tdata,          32'd0);
        chk("busy",      32'(busy),      32'd0);
        chk("done",      32'(done),      32'd0);
    endtask

    // mode 0: tready always 1; 1: random 50%; 2: ready one cycle in four
    typedef struct {
        logic [7:0]  addr;
        logic [8:0]  len;
        int          mode;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int beats, rds, done_cnt, first_rd, last_rd, first_vld, done_c;
        logic [31:0] pdata;
        logic        plast;
        logic [7:0]  ea;
        logic [7:0]  ed;
        bit          stalled, fin;
        beats = 0; rds = 0; done_cnt = 0; first_rd = -1; last_rd = -1;
        first_vld = -1; done_c = -1; stalled = 0; fin = 0; pdata = '0; plast = 1'b0;

        chk("cmd_ready before accept", 32'(cmd_ready), 32'd1);
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;

        for (int c = 1; c <= 600 && !fin; c++) begin
            case (v.mode)
                0:       tready = 1'b1;
                1:       tready = 1'($urandom_range(0, 1));
                default: tready = (c % 4 == 0);
            endcase
            chk("busy while running", 32'(busy), 32'(!done));
            if (bram_rden) begin
                ea = v.addr + 8'(rds);
                chk("read address order", 32'(bram_addr), 32'(ea));
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                rds++;
                chk("reads outstanding <= 4", 32'(rds - beats <= 4), 32'd1);
            end
            if (stalled) begin
                chk("tvalid held under stall", 32'(tvalid), 32'd1);
                chk("tdata held under stall",  tdata,       pdata);
                chk("tlast held under stall",  32'(tlast),  32'(plast));
            end
            if (tvalid) begin
                if (first_vld < 0) first_vld = c;
                ed = v.first[7:0] + 8'(beats);
                chk("beat data", tdata, {24'h0, ed});
                chk("tlast position", 32'(tlast), 32'(beats == int'(v.len) - 1));
                if (beats == int'(v.len) - 1) chk("final beat data", tdata, v.last);
                pdata   = tdata;
                plast   = tlast;
                stalled = !tready;
                if (tready) beats++;
            end else begin
                stalled = 0;
            end
            if (done) begin
                done_cnt++;
                done_c = c;
                chk("all beats before done", 32'(beats), 32'(v.len));
                chk("cmd_ready with done", 32'(cmd_ready), 32'd1);
                fin = 1;
            end
            tick();
        end
        tready = 1'b1;

        chk("done seen once", 32'(done_cnt), 32'd1);
        chk("done is a pulse", 32'(done), 32'd0);
        chk("idle after done", 32'(busy), 32'd0);
        chk("beat count", 32'(beats), 32'(v.len));
        chk("read count", 32'(rds), 32'(v.len));
        if (v.mode == 0) begin
            chk("first read cycle", 32'(first_rd), 32'd1);
            chk("reads contiguous", 32'(last_rd - first_rd + 1), 32'(v.len));
            chk("first tvalid cycle", 32'(first_vld), 32'd3);
            chk("done cycle", 32'(done_c), 32'(3 + int'(v.len)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [6];
        vec_t vr;
        logic [3:0]  wa [4];
        logic [31:0] wd [4];
        int beats, n, k, dseen;

        vt[0] = '{addr: 8'h10, len: 9'd8,  mode: 0, first: 32'h10, last: 32'h17};
        vt[1] = '{addr: 8'h20, len: 9'd16, mode: 1, first: 32'h20, last: 32'h2F};
        vt[2] = '{addr: 8'h00, len: 9'd1,  mode: 0, first: 32'h00, last: 32'h00};
        vt[3] = '{addr: 8'hFC, len: 9'd6,  mode: 0, first: 32'hFC, last: 32'h01};
        vt[4] = '{addr: 8'h30, len: 9'd8,  mode: 2, first: 32'h30, last: 32'h37};
        vt[5] = '{addr: 8'h80, len: 9'd24, mode: 1, first: 32'h80, last: 32'h97};
        wa = '{4'hE, 4'hF, 4'h0, 4'h1};
        wd = '{32'h10E, 32'h10F, 32'h100, 32'h101};

        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        for (int i = 0; i < 16; i++) smem[i] = 32'h100 + 32'(i);

        phase = "reset";
        rstn = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 8'h10; cmd_len = 9'd4; tready = 1'b1;
        s_cmd_valid = 1'b0; s_cmd_addr = 4'h0; s_cmd_len = 5'd0; s_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_outputs();
        end
        cmd_valid = 1'b0;
        rstn = 1'b1;
        tick();
        chk_idle_outputs();

        for (int i = 0; i < 6; i++) begin
            phase = $sformatf("vector %0d", i);
            run_vec(vt[i]);
        end

        phase = "zero length";
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_addr = 8'h05; cmd_len = 9'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("done pulse", 32'(done), 32'd1);
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        chk("busy", 32'(busy), 32'd0);
        chk("no read", 32'(bram_rden), 32'd0);
        dseen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dseen++;
            chk("no read", 32'(bram_rden), 32'd0);
            chk("no tvalid", 32'(tvalid), 32'd0);
        end
        chk("single done", 32'(dseen), 32'd0);

        phase = "mid reset";
        cmd_addr = 8'h00; cmd_len = 9'd32; cmd_valid = 1'b1; tready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        beats = 0;
        for (int c = 0; c < 100 && beats < 10; c++) begin
            if (tvalid) beats++;
            tick();
        end
        chk("beats before reset", 32'(beats), 32'd10);
        chk("still busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        tick();
        chk_idle_outputs();
        rstn = 1'b1;
        dseen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || tvalid || bram_rden) dseen++;
        end
        chk("quiet after reset", 32'(dseen), 32'd0);
        vr = '{addr: 8'h00, len: 9'd2, mode: 0, first: 32'h00, last: 32'h01};
        run_vec(vr);

        phase = "wrap";
        s_cmd_addr = 4'hE; s_cmd_len = 5'd4; s_cmd_valid = 1'b1; s_tready = 1'b1;
        chk("cmd_ready", 32'(s_cmd_ready), 32'd1);
        tick();
        s_cmd_valid = 1'b0;
        n = 0; k = 0; dseen = 0;
        for (int c = 0; c < 30 && dseen == 0; c++) begin
            if (s_bram_rden) begin
                if (n < 4) chk("wrap read address", 32'(s_bram_addr), 32'(wa[n]));
                n++;
            end
            if (s_tvalid) begin
                if (k < 4) begin
                    chk("wrap data", s_tdata, wd[k]);
                    chk("wrap tlast", 32'(s_tlast), 32'(k == 3));
                end
                k++;
            end
            if (s_done) dseen = 1;
            tick();
        end
        chk("wrap reads", 32'(n), 32'd4);
        chk("wrap beats", 32'(k), 32'd4);
        chk("wrap done", 32'(dseen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
